// File: rtl/codon_pkg.sv
// -----------------------------------------------------------------------------
// codon_pkg
// Shared types and constants for the codon stream histogram.
//   base_t   : 2-bit nucleotide encoding A=00 C=01 G=10 T=11
//   codon_t  : three bases packed, first base in [5:4]
//   state_t  : run-control FSM states
//   CODON_ATG: start codon, handy default target
// -----------------------------------------------------------------------------
package codon_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_t;

    typedef logic [5:0] codon_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam codon_t CODON_ATG = 6'b00_11_10;

endpackage

// File: rtl/codon_match_counter.sv
// -----------------------------------------------------------------------------
// codon_match_counter
// One target slot: compares the completed codon against its pattern and keeps a
// saturating occurrence count with a sticky overflow flag.
//   clock, reset : system clock, async active-high reset
//   pattern      : target codon for this slot
//   enable       : slot has been written; disabled slots never count
//   strobe       : a codon completed this cycle
//   codon        : the completed codon
//   clear        : synchronous clear of count and overflow (start of a run)
//   count        : registered occurrence count
//   overflow     : set when an increment is attempted at the maximum count
// -----------------------------------------------------------------------------
module codon_match_counter
    import codon_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  codon_t             pattern,
    input  logic               enable,
    input  logic               strobe,
    input  codon_t             codon,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               hit;

    assign hit = strobe && enable && (codon == pattern);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (hit) begin
            // At the ceiling the count holds and the miss is recorded instead.
            if (count_q == CNT_MAX) ovf_d = 1'b1;
            else                    count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/codon_stream_histogram.sv
// -----------------------------------------------------------------------------
// codon_stream_histogram
// Assembles a nucleotide stream into codons (framed or sliding window) and
// counts occurrences of up to NUM_PATTERNS programmable target codons.
//   clock, reset  : system clock, async active-high reset
//   start         : begin a run, clears counts (IDLE/DONE only)
//   overlap_mode  : 0 framed, 1 sliding window; latched at start
//   base_valid/base/base_last, base_ready : input stream.
//     Handshake: a beat transfers on a rising edge where base_valid and
//     base_ready are both 1; base_ready is 1 exactly while in RUN and does not
//     depend on base_valid. base/base_last are ignored when not transferred.
//   pattern_we/pattern_idx/pattern_data : program a target slot (not while busy)
//   query_idx/query_count : combinational read of one slot's count
//   busy, done    : run status
//   overflow      : sticky per-slot saturation flags
//   state_dbg     : current FSM state, for observation
// -----------------------------------------------------------------------------
module codon_stream_histogram
    import codon_pkg::*;
#(
    parameter  int NUM_PATTERNS = 5,
    parameter  int COUNT_W      = 4,
    localparam int IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    overlap_mode,
    input  logic                    base_valid,
    input  logic [1:0]              base,
    input  logic                    base_last,
    output logic                    base_ready,
    input  logic                    pattern_we,
    input  logic [IDX_W-1:0]        pattern_idx,
    input  logic [5:0]              pattern_data,
    input  logic [IDX_W-1:0]        query_idx,
    output logic [COUNT_W-1:0]      query_count,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_PATTERNS-1:0] overflow,
    output state_t                  state_dbg
);

    state_t                  state_q, state_d;
    logic                    start_run;
    logic                    accept;
    logic                    complete;
    codon_t                  cur_codon;

    logic                    mode_q;
    logic [3:0]              win_q;     // last two accepted bases
    logic [1:0]              fill_q;    // bases seen this run, saturates at 2
    logic [1:0]              phase_q;   // position within a framed codon

    codon_t                  pat_q [NUM_PATTERNS];
    logic [NUM_PATTERNS-1:0] en_q;
    logic [COUNT_W-1:0]      counts [NUM_PATTERNS];

    // ---------------- FSM ----------------
    always_comb begin
        state_d    = state_q;
        base_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_run  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                base_ready = 1'b1;
                busy       = 1'b1;
                if (base_valid && base_last) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign state_dbg = state_q;

    // ---------------- window / phase ----------------
    assign accept    = base_valid && base_ready;
    assign cur_codon = {win_q, base};
    assign complete  = accept && (mode_q ? (fill_q == 2'd2) : (phase_q == 2'd2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q  <= 1'b0;
            win_q   <= '0;
            fill_q  <= '0;
            phase_q <= '0;
        end else if (start_run) begin
            mode_q  <= overlap_mode;
            win_q   <= '0;
            fill_q  <= '0;
            phase_q <= '0;
        end else if (accept) begin
            win_q   <= {win_q[1:0], base};
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        end
    end

    // ---------------- pattern slots ----------------
    // Loop compare keeps out-of-range pattern_idx values harmless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PATTERNS; i++) pat_q[i] <= '0;
            en_q <= '0;
        end else if (pattern_we && !busy) begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                if (pattern_idx == IDX_W'(i)) begin
                    pat_q[i] <= pattern_data;
                    en_q[i]  <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_slot
        codon_match_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .pattern  (pat_q[g]),
            .enable   (en_q[g]),
            .strobe   (complete),
            .codon    (cur_codon),
            .clear    (start_run),
            .count    (counts[g]),
            .overflow (overflow[g])
        );
    end

    // ---------------- query mux ----------------
    always_comb begin
        query_count = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (query_idx == IDX_W'(i)) query_count = counts[i];
        end
    end

endmodule
